mem_access_unit: RTL and testbench

- Data-memory access stage of the pipeline. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU result as the address, plus write data and control, from the MEM stage.
- Runs a req/ack handshake with a variable-latency data memory and stalls the pipeline until the access completes.
- Presents the read data (RD) to the MEM/WB register.

---
 rtl/mem_pkg.sv | 12 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_access_unit.sv | 118 +++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the data-memory access stage.
package mem_pkg;
  localparam int MEM_DATA_W = 24;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_TIMEOUT_CYC = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter for an outstanding memory access; flags the last allowed cycle.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Counter holds at LAST, so expired stays asserted rather than wrapping.
  assign expired = (count_reg == LAST);
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: latches one load/store, runs req/ack with the data memory,
// stalls the pipeline until completion and presents load data to MEM/WB.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int TIMEOUT_CYC = MEM_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              memWriteM,
  input  logic              memToRegM,
  input  logic              flushM,
  output logic              stallM,
  output logic [DATA_W-1:0] RD,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);
  mem_state_t state_reg, state_next;

  logic              access;
  logic              start;
  logic              in_busy;
  logic              expired;
  logic              finish;
  logic              load_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rd_reg;
  logic              err_reg;

  assign access  = (memWriteM | memToRegM) & ~flushM;
  assign start   = (state_reg == IDLE) & access;
  assign in_busy = (state_reg == BUSY);
  assign finish  = in_busy & (mem_ack | expired);

  mem_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (in_busy),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    stallM     = 1'b0;
    mem_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        stallM = access;
        if (access) state_next = BUSY;
      end
      BUSY: begin
        stallM  = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || expired) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (start) begin
        addr_reg  <= ALUOutM;
        wdata_reg <= WriteDataM;
        we_reg    <= memWriteM;
        load_reg  <= memToRegM;
      end
      if (finish) begin
        // A combined load+store is illegal: the write goes out, the load returns zero.
        if (we_reg && load_reg) begin
          rd_reg  <= '0;
          err_reg <= 1'b1;
        end else if (mem_ack) begin
          if (load_reg) rd_reg <= mem_rdata;
        end else begin
          err_reg <= 1'b1;
          if (load_reg) rd_reg <= '0;
        end
      end
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign RD        = rd_reg;
  assign mem_err   = err_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses, all outputs
// compared every cycle against a transaction-level reference model.
module tb_mem_access_unit;
  localparam int DW = 24;
  localparam int AW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ALUOutM = '0;
  logic [DW-1:0] WriteDataM = '0;
  logic          memWriteM = 1'b0;
  logic          memToRegM = 1'b0;
  logic          flushM = 1'b0;
  logic          stallM;
  logic [DW-1:0] RD;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .memWriteM(memWriteM), .memToRegM(memToRegM), .flushM(flushM), .stallM(stallM),
    .RD(RD), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, tracked as "waiting N cycles" then
  // "completing", with results derived directly from the access rules.
  bit            m_pending, m_finished, m_store, m_load, m_err;
  int            m_waited;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd;

  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pending = 0; m_finished = 0; m_store = 0; m_load = 0; m_err = 0;
        m_waited = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
      end
      acc = (memWriteM || memToRegM) && !flushM;
      check("cyc_stallM", stallM, m_pending || (!m_pending && !m_finished && acc));
      check("cyc_mem_req", mem_req, m_pending);
      check("cyc_mem_we", mem_we, m_store);
      check("cyc_mem_addr", mem_addr, m_addr);
      check("cyc_mem_wdata", mem_wdata, m_wdata);
      check("cyc_RD", RD, m_rd);
      check("cyc_mem_err", mem_err, m_err);
      if (rst_n) begin
        if (m_finished) begin
          m_finished = 0;
        end else if (m_pending) begin
          if (mem_ack || m_waited == TO - 1) begin
            if (m_store && m_load) begin
              m_rd = '0; m_err = 1;
            end else if (mem_ack) begin
              if (m_load) m_rd = mem_rdata;
            end else begin
              m_err = 1;
              if (m_load) m_rd = '0;
            end
            m_pending = 0; m_finished = 1;
          end else begin
            m_waited++;
          end
        end else if (acc) begin
          m_pending = 1; m_waited = 0;
          m_addr = ALUOutM; m_wdata = WriteDataM; m_store = memWriteM; m_load = memToRegM;
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      memWriteM = 0; memToRegM = 0; flushM = 0; mem_ack = 0;
      mem_rdata = DW'($urandom);
    end
  endtask

  // Presents one instruction and plays the memory: ack in BUSY cycle ack_lat (0 = never),
  // optional flush raised in cycle flush_cyc, optional spurious ack in the DONE cycle.
  task automatic do_access(input bit w, input bit r, input bit f, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int ack_lat, input int flush_cyc,
                           input bit spur_done, input bit ack0, input logic [DW-1:0] rdata,
                           output int stall, output int reqs, output logic [AW-1:0] a_seen,
                           output logic we_seen, output logic [DW-1:0] wd_seen,
                           output logic [DW-1:0] rd_done);
    int cyc;
    int done_cyc;
    bit exited;
    done_cyc = (ack_lat >= 1 && ack_lat <= TO) ? ack_lat + 1 : TO + 1;
    @(posedge clk); #1;
    memWriteM = w; memToRegM = r; flushM = f; ALUOutM = a; WriteDataM = wd;
    mem_ack = ack0; mem_rdata = DW'($urandom);
    stall = 0; reqs = 0; cyc = 0; exited = 0;
    a_seen = '0; we_seen = 0; wd_seen = '0; rd_done = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) reqs++;
      if (cyc == 1) begin
        a_seen = mem_addr; we_seen = mem_we; wd_seen = mem_wdata;
      end
      if (!stallM) begin
        rd_done = RD;
        exited = 1;
        break;
      end
      stall++;
      @(posedge clk); #1;
      cyc++;
      mem_ack = (cyc == ack_lat) || (spur_done && cyc == done_cyc);
      if (cyc == flush_cyc) flushM = 1;
      mem_rdata = (cyc == ack_lat) ? rdata : DW'($urandom);
    end
    if (!exited) begin
      n_cmp++; n_bad++;
      $display("FAIL access_bound: stallM still high after 40 cycles, expected release");
    end
  endtask

  initial begin
    int st, rq;
    logic [AW-1:0] as;
    logic wes;
    logic [DW-1:0] wds, rdd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_RD", RD, 0);
    check("rst_err", mem_err, 0);
    check("rst_req", mem_req, 0);
    check("rst_stall", stallM, 0);
    @(posedge clk); #1 rst_n = 1;
    idle_cycles(2);

    // Load, ack in third BUSY cycle
    do_access(0, 1, 0, 16'h0040, 24'h0, 3, -1, 0, 0, 24'hABCDEF, st, rq, as, wes, wds, rdd);
    $display("load 0x0040: stall=%0d req=%0d RD=%h", st, rq, rdd);
    check("load_stall", st, 4);
    check("load_reqs", rq, 3);
    check("load_addr", as, 16'h0040);
    check("load_we", wes, 0);
    check("load_RD", rdd, 24'hABCDEF);

    // Store, ack in first BUSY cycle
    do_access(1, 0, 0, 16'h00FF, 24'h123456, 1, -1, 0, 0, 24'h0F0F0F, st, rq, as, wes, wds, rdd);
    $display("store 0x00FF: stall=%0d we=%0d wdata=%h RD=%h", st, wes, wds, rdd);
    check("store_stall", st, 2);
    check("store_we", wes, 1);
    check("store_wdata", wds, 24'h123456);
    check("store_addr", as, 16'h00FF);
    check("store_RD_kept", rdd, 24'hABCDEF);

    // Flushed load in IDLE
    do_access(0, 1, 1, 16'h0100, 24'h0, 2, -1, 0, 0, 24'h777777, st, rq, as, wes, wds, rdd);
    $display("flushed load: stall=%0d req=%0d", st, rq);
    check("flush_stall", st, 0);
    check("flush_req", rq, 0);
    idle_cycles(2);

    // Flush raised mid-BUSY is ignored
    do_access(0, 1, 0, 16'h0200, 24'h0, 3, 1, 0, 0, 24'h55AA33, st, rq, as, wes, wds, rdd);
    $display("midbusy flush load: stall=%0d RD=%h", st, rdd);
    check("midflush_stall", st, 4);
    check("midflush_RD", rdd, 24'h55AA33);

    // Back-to-back load then store, spurious ack in the load's DONE cycle
    do_access(0, 1, 0, 16'h0300, 24'h0, 2, -1, 1, 0, 24'h000777, st, rq, as, wes, wds, rdd);
    $display("b2b load: stall=%0d RD=%h", st, rdd);
    check("b2b_load_RD", rdd, 24'h000777);
    do_access(1, 0, 0, 16'h0304, 24'h00BEEF, 1, -1, 0, 0, 24'h0, st, rq, as, wes, wds, rdd);
    $display("b2b store: stall=%0d req=%0d addr=%h", st, rq, as);
    check("b2b_store_stall", st, 2);
    check("b2b_store_reqs", rq, 1);
    check("b2b_store_addr", as, 16'h0304);
    check("b2b_RD_kept", rdd, 24'h000777);

    // Load with no ack: timeout
    do_access(0, 1, 0, 16'h0400, 24'h0, 0, -1, 0, 0, 24'h0, st, rq, as, wes, wds, rdd);
    $display("timeout load: stall=%0d req=%0d RD=%h err=%0d", st, rq, rdd, mem_err);
    check("to_stall", st, 16);
    check("to_reqs", rq, 15);
    check("to_RD", rdd, 0);
    check("to_err", mem_err, 1);
    do_access(0, 1, 0, 16'h0404, 24'h0, 2, -1, 0, 0, 24'h111111, st, rq, as, wes, wds, rdd);
    $display("load after timeout: RD=%h err=%0d", rdd, mem_err);
    check("after_to_RD", rdd, 24'h111111);
    check("err_sticky", mem_err, 1);

    // Simultaneous load and store
    do_access(1, 1, 0, 16'h0500, 24'h222222, 2, -1, 0, 0, 24'h333333, st, rq, as, wes, wds, rdd);
    $display("load+store: we=%0d RD=%h", wes, rdd);
    check("both_we", wes, 1);
    check("both_RD", rdd, 0);

    // Reset in the middle of BUSY, then a late ack
    @(posedge clk); #1;
    memToRegM = 1; memWriteM = 0; flushM = 0; ALUOutM = 16'h0600; mem_ack = 0;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_req", mem_req, 1);
    #1 rst_n = 0;
    #1;
    $display("reset mid-busy: req=%0d RD=%h err=%0d", mem_req, RD, mem_err);
    check("midrst_req", mem_req, 0);
    check("midrst_RD", RD, 0);
    check("midrst_err", mem_err, 0);
    @(posedge clk); #1 memToRegM = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1 mem_ack = 1; mem_rdata = 24'hFFFFFF;
    @(posedge clk); #1 mem_ack = 0;
    @(negedge clk);
    check("late_ack_req", mem_req, 0);
    check("late_ack_RD", RD, 0);
    check("late_ack_stall", stallM, 0);

    // Randomized accesses
    for (int i = 0; i < 250; i++) begin
      bit w, r, f, spur, a0;
      int lat, fc;
      w    = ($urandom_range(0, 2) == 0);
      r    = ($urandom_range(0, 1) == 0);
      f    = ($urandom_range(0, 5) == 0);
      spur = ($urandom_range(0, 3) == 0);
      a0   = ($urandom_range(0, 5) == 0);
      lat  = $urandom_range(1, 18);
      fc   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1;
      do_access(w, r, f, AW'($urandom), DW'($urandom), lat, fc, spur, a0, DW'($urandom),
                st, rq, as, wes, wds, rdd);
      $display("rand %0d: w=%0d r=%0d f=%0d lat=%0d stall=%0d RD=%h err=%0d",
               i, w, r, f, lat, st, rdd, mem_err);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    idle_cycles(2);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
